image_uart_rx: RTL and testbench
================================

IMAGE_UART_RX -- requirements
Module: image_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz, 115200 baud); legal range 8..65535.
REQ-002 SHALL have parameter IMG_PIXELS, default 16384, bytes per frame (128x128 greyscale).
REQ-003 SHALL have parameter ADDR_W, default 14, original-image BRAM address width.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 enable  in  1  arm receiver; low = synchronous abort/clear.
REQ-007 RxD  in  1  UART serial line, idle high, asynchronous to clk.
REQ-008 ena  out  1  BRAM port enable.
REQ-009 wea  out  1  BRAM write enable.
REQ-010 addr  out  ADDR_W  BRAM write address.
REQ-011 din  out  8  BRAM write data.
REQ-012 rx_count  out  ADDR_W+1  bytes written in current frame.
REQ-013 rx_complete  out  1  frame fully written.
REQ-014 frame_err  out  1  sticky, stop bit sampled low.
REQ-015 parity_err  out  1  sticky, parity mismatch (tied 0 without RX_PARITY_EN).

Function
REQ-016 SHALL pass RxD through a 2-flop synchronizer (reset value 1) before any use.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WRITE, DONE, RECOVER.
REQ-018 IDLE: with enable high, synchronized RxD 1->0 SHALL enter START and load bit timer.
REQ-019 START: after CLKS_PER_BIT/2 cycles, SHALL resample; low -> DATA, high -> IDLE (glitch rejected, no flag).
REQ-020 DATA: SHALL sample 8 bits LSB-first, each exactly CLKS_PER_BIT cycles after the previous sample.
REQ-021 STOP: sample CLKS_PER_BIT after last data/parity bit; high -> WRITE; low -> set frame_err, discard byte, RECOVER.
REQ-022 RECOVER: SHALL wait for synchronized RxD high, then IDLE.
REQ-023 WRITE: exactly one cycle with ena=wea=1, addr=rx_count[ADDR_W-1:0], din=received byte; rx_count increments at the end of that cycle.
REQ-024 Outside WRITE, ena and wea SHALL be 0; addr/din hold last value.
REQ-025 When rx_count reaches IMG_PIXELS after a write, SHALL enter DONE; rx_complete=1 held while in DONE; further RxD traffic ignored.
REQ-026 Latency: WRITE strobe SHALL occur 1 cycle after the stop-bit sample cycle.
REQ-027 enable low in any state SHALL, next clock, return to IDLE, clear rx_count, rx_complete, frame_err, parity_err; an in-flight byte is discarded without write.
REQ-028 rx_count SHALL never exceed IMG_PIXELS; address never wraps within a frame.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, ena=0, wea=0, addr=0, din=0, rx_count=0, rx_complete=0, frame_err=0, parity_err=0, synchronizer=1, bit timer=0.
REQ-030 Reset mid-byte SHALL leave no partial write; first frame after release starts at addr 0.

Configuration
REQ-031 Macro IMAGE_UART_RX_PARITY_EN defined: SHALL expect one even-parity bit after data (PARITY state); mismatch sets parity_err and discards byte (no write, rx_count unchanged), then STOP handled normally.
REQ-032 Macro undefined: PARITY state and its logic SHALL not exist; frame is 8N1; parity_err constant 0.

Structure
REQ-033 State enum, default CLKS_PER_BIT, IMG_PIXELS, ADDR_W SHALL live in shared package img_pkg, also used by the transmit stage.
REQ-034 One sub-module uart_rx_sync (2-flop synchronizer with reset-to-1) SHALL be instantiated; remainder is flat.

Verification (bench CLKS_PER_BIT=16, IMG_PIXELS=4)
REQ-035 Send 0xA5,0x3C,0xFF,0x00 (8N1) -> writes addr 0..3 with those data, one-cycle wea each, rx_complete=1 after 4th, rx_count=4.
REQ-036 1-cycle low glitch (< 8 cycles) on idle RxD -> no write, no flag, state back to IDLE.
REQ-037 Byte 0x55 with stop bit low -> frame_err=1, no write, rx_count=0; next valid 0x12 -> written at addr 0.
REQ-038 enable dropped after 4th data bit of 2nd byte -> rx_count=0, flags clear; re-enable, send 4 bytes -> addr 0..3 written.
REQ-039 rst_n pulsed low mid-frame (rx_count=2) -> all outputs zero immediately, asynchronously of clk.
REQ-040 With IMAGE_UART_RX_PARITY_EN: 0x07 with odd parity bit -> parity_err=1, no write; 0x07 with parity 1 -> written.

Source files
------------

// File: rtl/img_pkg.sv
// Shared state encoding and default sizing for the image UART receive/transmit path.
// The PARITY state exists only when IMAGE_UART_RX_PARITY_EN is defined.
package img_pkg;

   localparam int DEF_CLKS_PER_BIT = 868;
   localparam int DEF_IMG_PIXELS   = 16384;
   localparam int DEF_ADDR_W       = 14;
   localparam int TIMER_W          = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef IMAGE_UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WRITE,
      DONE,
      RECOVER
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
// Latency: 2 cycles; no backpressure.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/image_uart_rx.sv
// UART byte receiver streaming one image frame into BRAM; IMAGE_UART_RX_PARITY_EN adds an even-parity bit.
// Latency: write strobe 1 cycle after the stop-bit sample; no backpressure (BRAM always accepts).
module image_uart_rx
   import img_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int IMG_PIXELS   = DEF_IMG_PIXELS,
   parameter int ADDR_W       = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              RxD,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        din,
   output logic [ADDR_W:0]   rx_count,
   output logic              rx_complete,
   output logic              frame_err,
   output logic              parity_err
);

   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W:0]    PIX_END   = (ADDR_W + 1)'(IMG_PIXELS);

   rx_state_t          state, state_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic               rx_s, rx_prev;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic [ADDR_W:0]    cnt_inc;
   logic               tick;
   logic               shift_en;
   logic               set_ferr;
`ifdef IMAGE_UART_RX_PARITY_EN
   logic               par_smp;
   logic               par_bad;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (RxD),
      .q     (rx_s)
   );

   assign tick        = (timer == '0);
   assign cnt_inc     = rx_count + (ADDR_W + 1)'(1);
   assign ena         = (state == WRITE);
   assign wea         = (state == WRITE);
   assign rx_complete = (state == DONE);

   always_comb begin
      state_nxt = state;
      timer_nxt = tick ? '0 : timer - TIMER_W'(1);
      shift_en  = 1'b0;
      set_ferr  = 1'b0;
`ifdef IMAGE_UART_RX_PARITY_EN
      par_smp   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               state_nxt = START;
               timer_nxt = HALF_LAST;
            end
         end
         START: begin
            if (tick) begin
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
                  timer_nxt = BIT_LAST;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_en  = 1'b1;
               timer_nxt = BIT_LAST;
               if (bit_idx == 3'd7) begin
`ifdef IMAGE_UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef IMAGE_UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               par_smp   = 1'b1;
               timer_nxt = BIT_LAST;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (!rx_s) begin
                  set_ferr  = 1'b1;
                  state_nxt = RECOVER;
               end
`ifdef IMAGE_UART_RX_PARITY_EN
               else if (par_bad) begin
                  state_nxt = IDLE;
               end
`endif
               else begin
                  state_nxt = WRITE;
               end
            end
         end
         WRITE:   state_nxt = (cnt_inc == PIX_END) ? DONE : IDLE;
         RECOVER: if (rx_s) state_nxt = IDLE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      // Disarming wins over everything, including a byte mid-flight.
      if (!enable) begin
         state_nxt = IDLE;
         timer_nxt = '0;
         shift_en  = 1'b0;
         set_ferr  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_prev   <= 1'b1;
         bit_idx   <= '0;
         shift     <= '0;
         addr      <= '0;
         din       <= '0;
         rx_count  <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_prev <= rx_s;
         if (state == START) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {rx_s, shift[7:1]};
         end
         // Capture address/data on entry so they hold after rx_count moves on.
         if (state_nxt == WRITE) begin
            addr <= rx_count[ADDR_W-1:0];
            din  <= shift;
         end
         if (!enable) begin
            rx_count  <= '0;
            frame_err <= 1'b0;
         end else begin
            if (state == WRITE) rx_count <= cnt_inc;
            if (set_ferr)       frame_err <= 1'b1;
         end
      end
   end

`ifdef IMAGE_UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else if (!enable) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == START) par_bad <= 1'b0;
         if (par_smp) begin
            par_bad <= (^shift) ^ rx_s;
            if ((^shift) ^ rx_s) parity_err <= 1'b1;
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_image_uart_rx.sv
// Directed/randomized bench for image_uart_rx with CLKS_PER_BIT=16, IMG_PIXELS=4.
// Writes seen on the BRAM port are compared against a frame-level byte model.
module tb_image_uart_rx;

   localparam int CPB    = 16;
   localparam int PIX    = 4;
   localparam int AW     = 2;
   localparam int GAP    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          RxD = 1'b1;
   logic          ena, wea;
   logic [AW-1:0] addr;
   logic [7:0]    din;
   logic [AW:0]   rx_count;
   logic          rx_complete, frame_err, parity_err;

   int tests = 0;
   int fails = 0;

   // Model: bytes accepted in the current frame, and expected {addr,data} writes.
   int            m_cnt = 0;
   logic [9:0]    exp_q[$];
   logic [9:0]    act_q[$];
   int            pulse_viol = 0;
   int            ena_viol = 0;
   logic          prev_wea = 1'b0;

   image_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .IMG_PIXELS   (PIX),
      .ADDR_W       (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .RxD         (RxD),
      .ena         (ena),
      .wea         (wea),
      .addr        (addr),
      .din         (din),
      .rx_count    (rx_count),
      .rx_complete (rx_complete),
      .frame_err   (frame_err),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wea) begin
         act_q.push_back({addr, din});
         if (prev_wea) pulse_viol++;
      end
      if (ena !== wea) ena_viol++;
      prev_wea = wea;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic [7:0] b);
      if (m_cnt < PIX) begin
         exp_q.push_back({m_cnt[AW-1:0], b});
         m_cnt++;
      end
   endtask

   task automatic model_clear();
      m_cnt = 0;
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwr"}, act_q.size(), exp_q.size());
      while (exp_q.size() > 0 && act_q.size() > 0)
         check({tag, "_wr"}, act_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      act_q.delete();
   endtask

   task automatic line_bit(input logic v);
      RxD = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      @(negedge clk);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef IMAGE_UART_RX_PARITY_EN
      line_bit(^b);
`endif
      line_bit(stop_v);
      RxD = 1'b1;
      repeat (GAP + $urandom_range(0, 7)) @(negedge clk);
   endtask

`ifdef IMAGE_UART_RX_PARITY_EN
   task automatic send_par_byte(input logic [7:0] b, input logic par);
      @(negedge clk);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(par);
      line_bit(1'b1);
      repeat (GAP) @(negedge clk);
   endtask
`endif

   task automatic rearm();
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] fixed [4];
      fixed[0] = 8'hA5; fixed[1] = 8'h3C; fixed[2] = 8'hFF; fixed[3] = 8'h00;

      // Reset state
      #12;
      check("rst_ena", ena, 0);
      check("rst_wea", wea, 0);
      check("rst_addr", addr, 0);
      check("rst_din", din, 0);
      check("rst_cnt", rx_count, 0);
      check("rst_cmp", rx_complete, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_perr", parity_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      repeat (4) @(negedge clk);

      // Full frame of four fixed bytes
      for (int i = 0; i < 4; i++) begin
         send_byte(fixed[i], 1'b1);
         model_accept(fixed[i]);
      end
      check_writes("frame1");
      check("frame1_cnt", rx_count, m_cnt);
      check("frame1_cmp", rx_complete, 1);

      // Traffic after completion is ignored
      send_byte(8'($urandom), 1'b1);
      check_writes("done_ign");
      check("done_cnt", rx_count, PIX);
      check("done_cmp", rx_complete, 1);

      // Disarm clears
      enable = 1'b0;
      @(negedge clk);
      check("dis_cnt", rx_count, 0);
      check("dis_cmp", rx_complete, 0);
      enable = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);

      // Short glitch on idle line
      RxD = 1'b0;
      @(negedge clk);
      RxD = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_writes("glitch");
      check("glitch_cnt", rx_count, 0);
      check("glitch_ferr", frame_err, 0);

      // Bad stop bit, then a good byte lands at address 0
      send_byte(8'h55, 1'b0);
      check_writes("ferr");
      check("ferr_flag", frame_err, 1);
      check("ferr_cnt", rx_count, 0);
      send_byte(8'h12, 1'b1);
      model_accept(8'h12);
      check_writes("after_ferr");
      check("after_ferr_cnt", rx_count, m_cnt);
      check("ferr_sticky", frame_err, 1);

      // Disarm in the middle of the second byte
      rearm();
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_accept(b);
      b = 8'($urandom);
      @(negedge clk);
      line_bit(1'b0);
      for (int i = 0; i < 4; i++) line_bit(b[i]);
      enable = 1'b0;
      RxD = 1'b1;
      @(negedge clk);
      check("abort_cnt", rx_count, 0);
      check("abort_ferr", frame_err, 0);
      check("abort_perr", parity_err, 0);
      repeat (8 * CPB) @(negedge clk);
      check_writes("abort");
      enable = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b1);
         model_accept(b);
      end
      check_writes("reframe");
      check("reframe_cnt", rx_count, PIX);
      check("reframe_cmp", rx_complete, 1);

      // Asynchronous reset in the middle of a frame
      rearm();
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b1);
         model_accept(b);
      end
      check_writes("pre_rst");
      check("pre_rst_cnt", rx_count, 2);
      @(negedge clk);
      line_bit(1'b0);
      line_bit(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_cnt", rx_count, 0);
      check("arst_addr", addr, 0);
      check("arst_din", din, 0);
      check("arst_wea", wea, 0);
      check("arst_ena", ena, 0);
      RxD = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      act_q.delete();
      repeat (4 * CPB) @(negedge clk);
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_accept(b);
      check_writes("post_rst");
      check("post_rst_cnt", rx_count, 1);

`ifdef IMAGE_UART_RX_PARITY_EN
      rearm();
      send_par_byte(8'h07, 1'b0);
      check_writes("par_bad");
      check("par_flag", parity_err, 1);
      check("par_cnt", rx_count, 0);
      send_par_byte(8'h07, 1'b1);
      model_accept(8'h07);
      check_writes("par_good");
      check("par_good_cnt", rx_count, 1);
`endif

      check("wea_width", pulse_viol, 0);
      check("ena_eq_wea", ena_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
